mem_port_arbiter: RTL and testbench

- Shares the single RAM read/write data port (`rw_*`) between two masters:
  - master 0: the CPU load/store/call/return path;
  - master 1: the program loader / I/O DMA path.
- Transactions use a request/acknowledge handshake.
- Contention is resolved round-robin.
- Each access runs through a three-state sequencer, so the RAM sees exactly one registered, glitch-free access per transaction.
- The block sits between the masters and the `ram` instance's `rw` port. The instruction-fetch `r` port is not arbitrated.

---
 rtl/tinker_mem_pkg.sv | 23 ++
 rtl/mem_arb_rr.sv | 21 ++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_mem_pkg.sv
// Shared types and constants for the RAM read/write port arbitration slice.
package tinker_mem_pkg;

    // Bytes per RAM word; addresses must be a multiple of this to be aligned.
    localparam int MEM_WORD_BYTES = 8;
    localparam int MEM_ALIGN_BITS = $clog2(MEM_WORD_BYTES);

    localparam int MEM_ADDR_W = 64;
    localparam int MEM_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// the master that was not granted last.
module mem_arb_rr (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    // Combinational grant selection.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_grant;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the RAM rw port between the CPU (master 0) and the loader/DMA
// path (master 1). Every transaction is one registered RAM access followed by
// a one-cycle response.
// Optional feature: define MEM_PORT_ARBITER_ALIGN_CHECK_EN to reject
// word-misaligned addresses without touching the RAM.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access in flight; sample requests, latch the winner
// ACCESS | rw_* driven from latched fields; RAM result captured at end
// RESP   | ack/rdata/err held for the granted master
module mem_port_arbiter
    import tinker_mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic [ADDR_W-1:0] rw_addr,
    output logic [DATA_W-1:0] rw_data_in,
    output logic              rw_write_en,
    input  logic [DATA_W-1:0] rw_data_out,
    input  logic              rw_error,

    output logic              busy
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]        state;
    logic              last_grant;
    logic              gnt_idx;
    logic              gnt_valid;

    logic              lat_idx;
    logic              lat_we;
    logic              lat_misalign;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_misalign;

    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    mem_arb_rr u_arb (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    // Mux the winning master's request fields.
    always_comb begin
        sel_we    = gnt_idx ? m1_we    : m0_we;
        sel_addr  = gnt_idx ? m1_addr  : m0_addr;
        sel_wdata = gnt_idx ? m1_wdata : m0_wdata;
    end

`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    // A misaligned access never reaches the RAM and always reports an error.
    assign sel_misalign = |sel_addr[MEM_ALIGN_BITS-1:0];
    assign resp_err     = rw_error | lat_misalign;
`else
    assign sel_misalign = 1'b0;
    assign resp_err     = rw_error;
`endif

    // Writes and suppressed accesses return zero read data.
    assign resp_rdata = (lat_we || lat_misalign) ? '0 : rw_data_out;

    assign busy = (state != ST_IDLE);

    // Sequencer: grant and latch in IDLE, one RAM strobe in ACCESS, release in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            lat_idx      <= 1'b0;
            lat_we       <= 1'b0;
            lat_misalign <= 1'b0;
            rw_addr      <= '0;
            rw_data_in   <= '0;
            rw_write_en  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        state        <= ST_ACCESS;
                        last_grant   <= gnt_idx;
                        lat_idx      <= gnt_idx;
                        lat_we       <= sel_we;
                        lat_misalign <= sel_misalign;
                        rw_addr      <= sel_misalign ? '0 : sel_addr;
                        rw_data_in   <= sel_wdata;
                        rw_write_en  <= sel_we & ~sel_misalign;
                    end
                end
                ST_ACCESS: begin
                    state       <= ST_RESP;
                    rw_write_en <= 1'b0;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    rw_write_en <= 1'b0;
                end
            endcase
        end
    end

    // Response registers: loaded at the end of ACCESS, cleared on return to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_ack   <= 1'b0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;
        end else if (state == ST_ACCESS) begin
            if (lat_idx) begin
                m1_ack   <= 1'b1;
                m1_rdata <= resp_rdata;
                m1_err   <= resp_err;
            end else begin
                m0_ack   <= 1'b1;
                m0_rdata <= resp_rdata;
                m0_err   <= resp_err;
            end
        end else if (state == ST_RESP) begin
            m0_ack   <= 1'b0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small RAM model on the rw port.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [63:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [63:0] m1_addr, m1_wdata, m1_rdata;
    logic [63:0] rw_addr, rw_data_in, rw_data_out;
    logic        rw_write_en, rw_error;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int wen_total = 0;

    logic [63:0] mem [0:511];
    logic        pre_we = 1'b0;
    logic [8:0]  pre_idx = '0;
    logic [63:0] pre_data = '0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .rw_addr(rw_addr), .rw_data_in(rw_data_in), .rw_write_en(rw_write_en),
        .rw_data_out(rw_data_out), .rw_error(rw_error),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 4 KiB, combinational read, out-of-range addresses flag an error.
    assign rw_data_out = mem[rw_addr[11:3]];
    assign rw_error    = (rw_addr >= 64'h1000);

    always @(posedge clk) begin
        if (rw_write_en) mem[rw_addr[11:3]] <= rw_data_in;
        else if (pre_we) mem[pre_idx] <= pre_data;
    end

    always @(negedge clk) if (rw_write_en) wen_total <= wen_total + 1;

    task automatic preload(input logic [63:0] addr, input logic [63:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = addr[11:3]; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one transaction on one master and collect the response.
    task automatic do_txn(input int idx, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, output int lat, output int who,
                          output logic [63:0] rdata, output logic err, output int wen);
        int w0;
        @(negedge clk);
        w0 = wen_total;
        if (idx == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        else          begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        lat = -1; who = -1; rdata = '0; err = 1'b0;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) begin
                lat   = k;
                who   = m1_ack ? 1 : 0;
                rdata = m1_ack ? m1_rdata : m0_rdata;
                err   = m1_ack ? m1_err : m0_err;
            end
        end
        m0_req = 0; m1_req = 0;
        @(posedge clk); #1;
        wen = wen_total - w0;
    endtask

    task automatic test_reset;
        int acks;
        #1;
        if ({m0_ack, m1_ack, m0_err, m1_err, busy, rw_write_en} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                               {m0_ack, m1_ack, m0_err, m1_err, busy, rw_write_en});
        end
        checks++;
        if ({m0_rdata, m1_rdata, rw_addr, rw_data_in} !== 256'b0) begin
            errors++; $display("FAIL reset_data: got nonzero data/address outputs");
        end
        checks++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        // Reset in the middle of an ACCESS write.
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 64'h40; m0_wdata = 64'h55;
        @(posedge clk); #1;
        if (rw_write_en !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL reset_pre_wen: got wen=%b busy=%b expected 1 1", rw_write_en, busy);
        end
        checks++;
        reset = 1'b0;
        #1;
        if ({rw_write_en, busy, m0_ack, m1_ack} !== 4'b0 || rw_addr !== 64'h0) begin
            errors++; $display("FAIL reset_mid: got wen=%b busy=%b ack=%b%b addr=%h expected all 0",
                               rw_write_en, busy, m0_ack, m1_ack, rw_addr);
        end
        checks++;
        m0_req = 0; m0_we = 0;
        @(negedge clk);
        reset = 1'b1;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) acks++;
        end
        if (acks !== 0 || mem[8] !== 64'h0) begin
            errors++; $display("FAIL reset_drop: got acks=%0d ram40=%h expected 0 0", acks, mem[8]);
        end
        checks++;
    endtask

    task automatic test_single_read;
        int lat, who, wen; logic [63:0] rd; logic er;
        preload(64'h40, 64'hDEADBEEF);
        do_txn(0, 0, 64'h40, 64'h0, lat, who, rd, er, wen);
        if (lat !== 2 || who !== 0) begin
            errors++; $display("FAIL read_latency: got lat=%0d who=%0d expected 2 0", lat, who);
        end
        checks++;
        if (rd !== 64'hDEADBEEF || er !== 1'b0) begin
            errors++; $display("FAIL read_data: got %h err=%b expected deadbeef 0", rd, er);
        end
        checks++;
        if (busy !== 1'b0 || m0_ack !== 1'b0 || m0_rdata !== 64'h0) begin
            errors++; $display("FAIL read_release: got busy=%b ack=%b rdata=%h expected 0 0 0",
                               busy, m0_ack, m0_rdata);
        end
        checks++;
    endtask

    task automatic test_write_read;
        int lat, who, wen; logic [63:0] rd; logic er;
        do_txn(1, 1, 64'h80, 64'h1234, lat, who, rd, er, wen);
        if (lat !== 2 || who !== 1 || wen !== 1) begin
            errors++; $display("FAIL write_txn: got lat=%0d who=%0d wen_cycles=%0d expected 2 1 1", lat, who, wen);
        end
        checks++;
        if (rd !== 64'h0 || er !== 1'b0 || mem[16] !== 64'h1234) begin
            errors++; $display("FAIL write_result: got rdata=%h err=%b ram=%h expected 0 0 1234", rd, er, mem[16]);
        end
        checks++;
        do_txn(0, 0, 64'h80, 64'h0, lat, who, rd, er, wen);
        if (lat !== 2 || who !== 0 || rd !== 64'h1234 || wen !== 0) begin
            errors++; $display("FAIL readback: got lat=%0d who=%0d rdata=%h wen=%0d expected 2 0 1234 0",
                               lat, who, rd, wen);
        end
        checks++;
    endtask

    task automatic test_contention;
        int order [4]; int at [4]; int n; int cyc; int both;
        // Fresh reset so last_grant=1 and master 0 takes the first tie.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        m0_req = 1; m0_we = 0; m0_addr = 64'h40;
        m1_req = 1; m1_we = 0; m1_addr = 64'h80;
        n = 0; cyc = 0; both = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (m0_ack && m1_ack) both++;
            if (m0_ack || m1_ack) begin
                order[n] = m1_ack ? 1 : 0;
                at[n]    = cyc;
                if (m1_ack && m1_rdata !== 64'h1234) begin
                    errors++; $display("FAIL cont_rdata1: got %h expected 1234", m1_rdata);
                end
                if (m0_ack && m0_rdata !== 64'hDEADBEEF) begin
                    errors++; $display("FAIL cont_rdata0: got %h expected deadbeef", m0_rdata);
                end
                checks++;
                n++;
            end
        end
        m0_req = 0; m1_req = 0;
        if (n !== 4 || both !== 0) begin
            errors++; $display("FAIL cont_count: got acks=%0d simultaneous=%0d expected 4 0", n, both);
        end else begin
            if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin
                errors++; $display("FAIL cont_order: got %0d%0d%0d%0d expected 0101",
                                   order[0], order[1], order[2], order[3]);
            end
            checks++;
            if (at[0] !== 2 || at[1] !== 5 || at[2] !== 8 || at[3] !== 11) begin
                errors++; $display("FAIL cont_spacing: got %0d %0d %0d %0d expected 2 5 8 11",
                                   at[0], at[1], at[2], at[3]);
            end
        end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_ram_error;
        int lat, who, wen; logic [63:0] rd; logic er;
        do_txn(0, 0, 64'hFFFF_FFF8, 64'h0, lat, who, rd, er, wen);
        if (lat !== 2 || who !== 0 || er !== 1'b1) begin
            errors++; $display("FAIL ram_error: got lat=%0d who=%0d err=%b expected 2 0 1", lat, who, er);
        end
        checks++;
    endtask

    task automatic test_alignment;
        int lat, who, wen; logic [63:0] rd; logic er;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
        do_txn(0, 1, 64'h43, 64'hCAFE, lat, who, rd, er, wen);
        if (lat !== 2 || wen !== 0 || er !== 1'b1 || rd !== 64'h0) begin
            errors++; $display("FAIL align_reject: got lat=%0d wen=%0d err=%b rdata=%h expected 2 0 1 0",
                               lat, wen, er, rd);
        end
        checks++;
        if (mem[8] !== 64'hDEADBEEF) begin
            errors++; $display("FAIL align_ram: got %h expected deadbeef", mem[8]);
        end
        checks++;
`else
        // Without the check a misaligned read passes straight through.
        logic [63:0] seen_addr;
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 64'h43;
        @(posedge clk); #1;
        seen_addr = rw_addr;
        @(posedge clk); #1;
        rd = m0_rdata; er = m0_err; lat = m0_ack ? 2 : -1;
        m0_req = 0;
        @(posedge clk); #1;
        if (seen_addr !== 64'h43 || lat !== 2 || er !== 1'b0 || rd !== 64'hDEADBEEF) begin
            errors++; $display("FAIL align_pass: got addr=%h lat=%0d err=%b rdata=%h expected 43 2 0 deadbeef",
                               seen_addr, lat, er, rd);
        end
        checks++;
`endif
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 64'h0;
        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_ram_error();
        test_alignment();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
